ccff_bitstream_loader: RTL
==========================

# ccff_bitstream_loader

Configuration-chain writer for the `fpga_top` fabric. It accepts a bitstream over a valid/ready stream, one word per chain shift with one bit per configuration chain. It drives the fabric's parallel `ccff_head` chains, gates fabric shifting, and sequences `config_enable` and the fabric programming reset. It sits between the SoC-side bitstream source (DMA or testbench) and the fabric's `ccff_head`/`ccff_tail`/`pReset`/`config_enable` pins. It is the loading end of the chain that the fabric itself only receives.

## Interface
Parameters:
- `NUM_CHAINS`, default 12: number of parallel ccff chains; also the stream word width.
- `CHAIN_LEN`, default 1024: shifts per load, equal to the length of the longest chain; shorter chains are padded at the front of the stream.
- `RST_CYCLES`, default 4: prog_clk cycles that `fabric_pReset` is held before loading; must be at least 1.

Ports:
- `prog_clk` in 1: programming clock; all state is on its rising edge.
- `pReset_n` in 1: asynchronous, active-low block reset.
- `start` in 1: begin a load; sampled only in IDLE.
- `abort` in 1: synchronous cancel from any non-IDLE state.
- `s_valid` in 1: stream word valid.
- `s_ready` out 1: stream word accepted when `s_valid` and `s_ready` are both high.
- `s_data` in NUM_CHAINS: bit i feeds chain i.
- `ccff_head` out NUM_CHAINS: registered chain inputs to the fabric.
- `ccff_tail` in NUM_CHAINS: chain outputs from the fabric.
- `ccff_shift_en` out 1: enable for the external ICG on the fabric `prog_clk`.
- `config_enable` out 1: fabric configuration enable.
- `fabric_pReset` out 1: active-high fabric programming reset.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a load completes.
- `tail_sig` out NUM_CHAINS: readback signature. Present only with `CCFF_TAIL_SIG_EN`.

## Operation
- States: IDLE, CLEAR, LOAD, DRAIN, DONE.
- IDLE -> CLEAR on `start`.
  - On that edge: the shift counter clears and `tail_sig` clears.
- CLEAR:
  - `fabric_pReset`=1 and `config_enable`=1.
  - Lasts exactly RST_CYCLES cycles, then goes to LOAD.
- LOAD:
  - `s_ready`=1 and `config_enable`=1.
  - On each accept: `ccff_head` <= `s_data`, `ccff_shift_en` <= 1, and the counter increments. Otherwise `ccff_shift_en` <= 0 and `ccff_head` holds.
  - A stall on `s_valid` simply withholds the shift. No error is raised.
  - The CHAIN_LEN-th accept moves to DRAIN.
- DRAIN:
  - One cycle in which the final registered shift is performed. `s_ready`=0 and `config_enable`=1.
  - Then goes to DONE.
- DONE:
  - One cycle with `done`=1 and `config_enable`=0, then goes to IDLE.
- `abort` in CLEAR, LOAD or DRAIN:
  - The next state is IDLE.
  - `config_enable`, `fabric_pReset`, `ccff_shift_en` and `s_ready` are 0 from the next cycle.
  - `done` is not pulsed and the fabric configuration is undefined.
  - `abort` in DONE is ignored.
- `start` while `busy` is ignored.
- `start` and `abort` together in IDLE: `start` wins, because `abort` has no effect in IDLE.
- Counter width is `$clog2(CHAIN_LEN+1)`; it never wraps within a load.

## Timing
- Reset values: every output is 0 (`s_ready`, `ccff_head`, `ccff_shift_en`, `config_enable`, `fabric_pReset`, `busy`, `done`, `tail_sig`); the state is IDLE.
- Asserting `pReset_n` mid-load drops all outputs immediately, without waiting for a clock edge.
- `s_ready` is a registered state decode, and does not depend combinationally on `s_valid`.
- Latency from an accepted word to the fabric shift: that word appears on `ccff_head` together with `ccff_shift_en`=1 in the following cycle, and the fabric captures it at the end of that cycle.
- Minimum load with no stalls, `start` edge to the `done` pulse: 1 + RST_CYCLES + CHAIN_LEN + 1 cycles.
- The first bit accepted reaches `ccff_tail` CHAIN_LEN shifts later, so after a full load it sits at the tail end of every chain.

## Configuration
- Macro `CCFF_TAIL_SIG_EN`, when defined:
  - `tail_sig` is `tail_sig ^ ccff_tail` on every cycle in which `ccff_shift_en`=1.
  - It is cleared on `start` and held after DONE, giving an XOR signature of the previous configuration as it shifts out.
- When the macro is undefined: the `tail_sig` port and its register are absent, and `ccff_tail` is unused.

## Test plan
- Defaults, `start`, 1024 words 12'h001, 12'h002, … with no stalls:
  - `fabric_pReset` is high for exactly 4 cycles.
  - `ccff_shift_en` pulses exactly 1024 times.
  - `done` pulses once, 1030 cycles after the `start` edge.
  - `config_enable` falls in the DONE cycle.
- Same load with `s_valid` low on every third cycle:
  - `ccff_shift_en` count is still 1024.
  - `ccff_head` sequence is identical to the no-stall run.
  - `done` is delayed by the stall count.
- `abort` after 500 accepts:
  - IDLE next cycle; `config_enable`=0 and `s_ready`=0.
  - No `done` pulse.
  - A following `start` reloads cleanly with a full 1024 shifts.
- `pReset_n` pulsed low mid-LOAD between clock edges: all outputs are 0 before the next `prog_clk` edge, and `busy`=0.
- With `CCFF_TAIL_SIG_EN` and a fabric model of CHAIN_LEN-deep shift registers:
  - Load all-ones, then load zeros.
  - `tail_sig` after the second load equals 12'h000, because CHAIN_LEN is even.
  - Loading pattern 12'hA5A once more over a fabric holding a single 12'hA5A word and otherwise zeros yields `tail_sig`=12'hA5A.
- `start` held high throughout a load: exactly one load occurs per IDLE entry, and `start` pulses while `busy` are ignored.

Source files
------------

// File: rtl/ccff_bitstream_loader.sv
// Bitstream loader for the fpga_top configuration chains.
// Ports: prog_clk/pReset_n clock and async reset; start/abort control;
// s_valid/s_ready/s_data stream in; ccff_head/ccff_shift_en/
// config_enable/fabric_pReset to the fabric; ccff_tail from the fabric;
// busy/done status; tail_sig readback when CCFF_TAIL_SIG_EN is defined.
module ccff_bitstream_loader #(
  parameter int NUM_CHAINS = 12,
  parameter int CHAIN_LEN  = 1024,
  parameter int RST_CYCLES = 4
) (
  input  logic                  prog_clk,
  input  logic                  pReset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [NUM_CHAINS-1:0] s_data,
  output logic [NUM_CHAINS-1:0] ccff_head,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic                  ccff_shift_en,
  output logic                  config_enable,
  output logic                  fabric_pReset,
  output logic                  busy,
  output logic                  done
`ifdef CCFF_TAIL_SIG_EN
  ,
  output logic [NUM_CHAINS-1:0] tail_sig
`endif
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    DRAIN,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [RW-1:0]         rcnt_q, rcnt_d;
  logic [NUM_CHAINS-1:0] head_q, head_d;
  logic                  shen_q, shen_d;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      head_q  <= '0;
      shen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      head_q  <= head_d;
      shen_q  <= shen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    head_d  = head_q;
    shen_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          cnt_d   = '0;
          rcnt_d  = '0;
        end
      end
      CLEAR: begin
        if (abort) begin
          state_d = IDLE;
        end else if (rcnt_q == RW'(RST_CYCLES - 1)) begin
          state_d = LOAD;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (s_valid) begin
          head_d = s_data;
          shen_d = 1'b1;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(CHAIN_LEN - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = abort ? IDLE : DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status/handshake outputs are pure decodes of the state register,
  // so they clear with the async reset and never see s_valid.
  assign busy          = (state_q != IDLE);
  assign s_ready       = (state_q == LOAD);
  assign fabric_pReset = (state_q == CLEAR);
  assign config_enable = (state_q == CLEAR) ||
                         (state_q == LOAD)  ||
                         (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign ccff_head     = head_q;
  assign ccff_shift_en = shen_q;

`ifdef CCFF_TAIL_SIG_EN
  logic [NUM_CHAINS-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (state_q == IDLE && start) begin
      sig_d = '0;
    end else if (shen_q) begin
      sig_d = sig_q ^ ccff_tail;
    end
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign tail_sig = sig_q;
`else
  logic unused_tail;
  assign unused_tail = ^ccff_tail;
`endif

endmodule
